// File: rtl/ahb_slave_pkg.sv
// rtl/ahb_slave_pkg.sv - shared types and defaults for the AHB word-addressed slave
//
// Contents:
//   htrans_e          AHB transfer type encoding (IDLE, BUSY, NONSEQ, SEQ)
//   ADDR_W_DEFAULT    default word-address width
//   DATA_W_DEFAULT    default data width
//   htrans_is_active  true for transfer types that carry a real access
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 32;

    // SEQ is handled exactly like NONSEQ: the master supplies every address.
    function automatic logic htrans_is_active(input logic [1:0] htrans);
        return (htrans == NONSEQ) || (htrans == SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - word storage with one synchronous write port and one async read port
//
// Optional feature macro: AHB_SLAVE_HRDATA_EN (adds the read port).
//
// Ports:
//   clk    in   write clock
//   we     in   write enable, sampled on rising clk
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address (AHB_SLAVE_HRDATA_EN only)
//   rdata  out  combinational read data (AHB_SLAVE_HRDATA_EN only)
//
// The array is intentionally not reset: contents survive hresetn.
module ahb_slave_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
`ifdef AHB_SLAVE_HRDATA_EN
    ,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
`endif
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef AHB_SLAVE_HRDATA_EN
    assign rdata = mem[raddr];
`endif

endmodule

// File: rtl/ahb_slave.sv
// rtl/ahb_slave.sv - zero-wait-state AHB slave with address/data-phase pipeline over word storage
//
// Optional feature macro: AHB_SLAVE_HRDATA_EN (adds hrdata output and memory read path).
//
// Ports:
//   hclk     in   clock, all state on rising edge
//   hresetn  in   asynchronous active-low reset
//   htrans   in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite   in   1 = write, 0 = read
//   haddr    in   word address
//   hwdata   in   write data, valid in the data phase
//   hready   out  slave ready; 0 in reset, 1 from the first edge after release
//   hrdata   out  read data during a valid read data phase, else 0 (AHB_SLAVE_HRDATA_EN only)
//
// Storage lives in u_mem (array u_mem.mem).
module ahb_slave
    import ahb_slave_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hready
`ifdef AHB_SLAVE_HRDATA_EN
    ,
    output logic [DATA_W-1:0] hrdata
`endif
);

    logic [ADDR_W-1:0] addr_d,   addr_q;
    logic              write_d,  write_q;
    logic              valid_d,  valid_q;
    logic              hready_d, hready_q;

    logic              mem_we;

    // Address phase is captured every cycle; since hready never drops there
    // is no need to qualify the capture with it.
    always_comb begin
        addr_d   = haddr;
        write_d  = hwrite;
        valid_d  = htrans_is_active(htrans);
        hready_d = 1'b1;
    end

    // Async clear of valid_q drops any pending data-phase write the moment
    // reset is asserted, even mid-transfer.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            valid_q  <= 1'b0;
            hready_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            write_q  <= write_d;
            valid_q  <= valid_d;
            hready_q <= hready_d;
        end
    end

    assign hready = hready_q;

    // Data phase: the registered address pairs with the hwdata present now.
    assign mem_we = valid_q && write_q;

`ifdef AHB_SLAVE_HRDATA_EN
    logic [DATA_W-1:0] mem_rdata;

    ahb_slave_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (hwdata),
        .raddr (addr_q),
        .rdata (mem_rdata)
    );

    // Any write to the same word committed on the previous edge is already
    // in the array, so read-after-write returns the new data.
    assign hrdata = (valid_q && !write_q) ? mem_rdata : '0;
`else
    ahb_slave_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (hwdata)
    );
`endif

endmodule

// File: tb/tb_ahb_slave.sv
// tb/tb_ahb_slave.sv - self-checking bench for ahb_slave with randomized traffic and reference model
module tb_ahb_slave;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              hclk;
    logic              hresetn;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
`ifdef AHB_SLAVE_HRDATA_EN
    logic [DATA_W-1:0] hrdata;
`endif

    ahb_slave #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .htrans  (htrans),
        .hwrite  (hwrite),
        .haddr   (haddr),
        .hwdata  (hwdata),
        .hready  (hready)
`ifdef AHB_SLAVE_HRDATA_EN
        ,
        .hrdata  (hrdata)
`endif
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: memory contents plus the one outstanding address phase.
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic              pend_valid;
    logic              pend_write;
    logic [ADDR_W-1:0] pend_addr;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock, update the model with the inputs as seen at the
    // edge, then check the DUT against it.
    task automatic tick();
        logic              committed;
        logic [ADDR_W-1:0] caddr;
        logic [DATA_W-1:0] exp_rd;
        committed = 1'b0;
        caddr     = '0;
        @(posedge hclk);
        #1;
        if (hresetn) begin
            if (pend_valid && pend_write) begin
                model_mem[pend_addr] = hwdata;
                committed = 1'b1;
                caddr     = pend_addr;
            end
            pend_valid = (htrans == 2'b10) || (htrans == 2'b11);
            pend_write = hwrite;
            pend_addr  = haddr;
            check("hready_run", {31'b0, hready}, 32'd1);
            if (committed) begin
                check("commit", dut.u_mem.mem[caddr], model_mem[caddr]);
            end
`ifdef AHB_SLAVE_HRDATA_EN
            exp_rd = (pend_valid && !pend_write) ? model_mem[pend_addr] : '0;
            check("hrdata", hrdata, exp_rd);
`endif
        end else begin
            pend_valid = 1'b0;
            check("hready_rst", {31'b0, hready}, 32'd0);
`ifdef AHB_SLAVE_HRDATA_EN
            check("hrdata_rst", hrdata, 32'd0);
`endif
        end
    endtask

    task automatic drive(input logic [1:0] t, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        htrans = t;
        hwrite = w;
        haddr  = a;
        hwdata = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 'x;
        pend_valid = 1'b0;
        pend_write = 1'b0;
        pend_addr  = '0;
        hresetn    = 1'b0;
        drive(2'b00, 1'b0, '0, '0);

        // Reset held for 5 cycles.
        repeat (5) tick();

        // Release away from the edge; first address phase is an IDLE write.
        hresetn = 1'b1;
        drive(2'b00, 1'b1, 8'h10, 32'hdeadbeef);
        check("hready_before_first_edge", {31'b0, hready}, 32'd0);
        tick();
        drive(2'b01, 1'b1, 8'h11, 32'hcafef00d);
        tick();
        drive(2'b00, 1'b0, 8'h00, 32'h12345678);
        tick();
        check("idle_no_write", dut.u_mem.mem[8'h10], 32'hxxxxxxxx);
        check("busy_no_write", dut.u_mem.mem[8'h11], 32'hxxxxxxxx);

        // Single NONSEQ writes; visible 1ns after the second edge.
        drive(2'b10, 1'b1, 8'h0d, 32'h0);
        tick();
        drive(2'b00, 1'b0, 8'h00, 32'h5a5a5a5a);
        tick();
        check("write_0d", dut.u_mem.mem[8'h0d], 32'h5a5a5a5a);
        drive(2'b10, 1'b1, 8'h0c, 32'hffffffff);
        tick();
        drive(2'b00, 1'b0, 8'h00, 32'h0);
        tick();
        check("write_0c_zero", dut.u_mem.mem[8'h0c], 32'h0);

        // Back-to-back pipelined writes.
        for (int i = 0; i <= 10; i++) begin
            drive(2'b10, 1'b1, 8'(8'h99 - i), (i == 0) ? 32'h0 : 32'(32'hfff - (i - 1)));
            tick();
        end
        drive(2'b00, 1'b0, 8'h00, 32'(32'hfff - 10));
        tick();
        for (int n = 0; n <= 10; n++) begin
            check("b2b", dut.u_mem.mem[8'(8'h99 - n)], 32'(32'hfff - n));
        end

`ifdef AHB_SLAVE_HRDATA_EN
        // Read directly after write to the same word.
        drive(2'b10, 1'b1, 8'h03, 32'h0);
        tick();
        drive(2'b10, 1'b0, 8'h03, 32'h33);
        tick();
        check("raw_hrdata", hrdata, 32'h33);
        drive(2'b00, 1'b0, 8'h00, 32'h0);
        tick();
`endif

        // Randomized traffic, addresses biased to a small window for overwrites.
        for (int c = 0; c < 400; c++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                  $urandom);
            tick();
        end

        // Reset asserted during the data phase of a write: that write is dropped.
        drive(2'b10, 1'b1, 8'h20, 32'h0);
        tick();
        hwdata  = 32'hbad0bad0;
        #2;
        hresetn = 1'b0;
        pend_valid = 1'b0;
        #1;
        check("hready_async_rst", {31'b0, hready}, 32'd0);
        tick();
        check("rst_discard", dut.u_mem.mem[8'h20], model_mem[8'h20]);
        tick();
        hresetn = 1'b1;
        drive(2'b00, 1'b0, 8'h00, 32'h0);
        check("hready_after_rst", {31'b0, hready}, 32'd0);
        tick();
        tick();

        // Whole-array sweep: catches stray writes and lost writes anywhere.
        for (int a = 0; a < DEPTH; a++) begin
            check("sweep", dut.u_mem.mem[a[ADDR_W-1:0]], model_mem[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
